// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of pwm_in per PWM cycle and flags stuck lines.
// Define PWM_CAPTURE_SYNC_EN to insert a 2-flop synchronizer on pwm_in for asynchronous sources.
module pwm_capture #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pwm_in,
  output logic [COUNT_WIDTH-1:0] high_count,
  output logic [COUNT_WIDTH-1:0] period_count,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun,
  output logic                   stuck_high,
  output logic                   stuck_low
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] MEAS_HIGH = 2'd2;
  localparam logic [1:0] MEAS_LOW  = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] hi_tmp;
  logic                   cnt_sat;
  logic                   latch_hi;
  logic                   publish;
  logic                   set_high;
  logic                   set_low;

`ifdef PWM_CAPTURE_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = pwm_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) s_d <= 1'b0;
    else       s_d <= s;
  end

  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign cnt_sat = (cnt == CNT_MAX);

  // Saturation wins over edges: a measuring cycle that reaches all-ones is a stuck line.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_next = state;
    latch_hi   = 1'b0;
    publish    = 1'b0;
    set_high   = 1'b0;
    set_low    = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) state_next = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          if (cnt_sat) begin
            state_next = WAIT_RISE;
            set_high   = s;
            set_low    = ~s;
          end else if (fall) begin
            latch_hi   = 1'b1;
            state_next = MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          if (cnt_sat) begin
            state_next = WAIT_RISE;
            set_high   = s;
            set_low    = ~s;
          end else if (rise) begin
            publish    = 1'b1;
            state_next = MEAS_HIGH;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || state == IDLE) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (!cnt_sat) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         hi_tmp <= '0;
    else if (latch_hi) hi_tmp <= cnt;
  end

  // A publish into an occupied, unaccepted slot is dropped and reported via overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_count   <= '0;
      period_count <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (!enable) begin
        result_valid <= 1'b0;
      end else if (publish) begin
        if (!result_valid || result_ready) begin
          high_count   <= hi_tmp;
          period_count <= cnt;
          result_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else if (set_high) begin
      stuck_high <= 1'b1;
    end else if (set_low) begin
      stuck_low <= 1'b1;
    end else if (rise) begin
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end
  end

endmodule
